fabric_config_loader: RTL and testbench

// Streams a configuration frame in over the 8-bit data-input pins and programs every FU/switchbox
// of the NUM_FU_ROWS x NUM_FU_COLS array. Cells are loaded into a shadow bank and copied to the

---
 rtl/fabric_config_loader.sv | 186 ++++++++++++++++++
 tb/tb_fabric_config_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fabric_config_loader.sv
// fabric_config_loader: receives a configuration frame over the 8-bit input pins,
// writes the cells into a shadow bank, and copies that bank to the active bank in a
// single cycle.
// Optional feature macro: CFG_CHECKSUM_EN adds a trailing XOR checksum word and a
// CHECK state. Without the macro, LOAD goes straight to COMMIT after the last cell.
//
// state  | meaning
// IDLE   | discard words until SYNC_WORD
// LOAD   | write one cell per accepted word into the shadow bank
// CHECK  | compare the trailing checksum word (CFG_CHECKSUM_EN only)
// COMMIT | one cycle: copy shadow to active and pulse cfg_commit_o

`timescale 1ns/1ps

package fabric_config_pkg;
   localparam int NUM_FU_ROWS         = 4;
   localparam int NUM_FU_COLS         = 4;
   localparam int NUM_DATA_INPUT_PINS = 8;
   localparam int FU_COLS_BITS        = $clog2(NUM_FU_COLS);

   localparam logic [2:0] MODE_A_ADD = 3'd0;

   typedef struct packed {
      logic [2:0] mode;
   } fu_program_data_t;

   typedef struct packed {
      logic [FU_COLS_BITS-1:0] a_sel;
      logic [FU_COLS_BITS-1:0] b_sel;
   } sb_program_data_t;
endpackage

module fabric_config_loader
   import fabric_config_pkg::*;
#(
   parameter int                  IN_WIDTH  = NUM_DATA_INPUT_PINS,
   parameter int                  NUM_CELLS = NUM_FU_ROWS * NUM_FU_COLS,
   parameter logic [IN_WIDTH-1:0] SYNC_WORD = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_WIDTH-1:0]   cfg_data_i,
   input  logic                  cfg_valid_i,
   output logic                  cfg_ready_o,
   input  logic                  abort_i,
   output fu_program_data_t      fu_program_o [NUM_CELLS],
   output sb_program_data_t      sb_program_o [NUM_CELLS],
   output logic                  cfg_commit_o,
   output logic                  cfg_loaded_o,
   output logic                  busy_o,
   output logic                  error_o
);

   localparam int CELL_BITS = 3 + 2 * FU_COLS_BITS;
   localparam int IDX_W     = $clog2(NUM_CELLS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q;
   logic [CELL_BITS-1:0]   shadow_q [NUM_CELLS];
   logic [CELL_BITS-1:0]   active_q [NUM_CELLS];
   logic                   error_q;
   logic                   loaded_q;
   logic                   xfer;
   logic                   is_sync;
   logic                   rsvd_err;
   logic                   last_cell;
`ifdef CFG_CHECKSUM_EN
   logic [IN_WIDTH-1:0]    csum_q;
`endif

   // abort_i takes priority over any transfer, including a SYNC_WORD seen in IDLE
   assign xfer      = cfg_valid_i && cfg_ready_o && !abort_i;
   assign is_sync   = (cfg_data_i == SYNC_WORD);
   assign rsvd_err  = |cfg_data_i[IN_WIDTH-1:CELL_BITS];
   assign last_cell = (idx_q == LAST_IDX);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (xfer && is_sync) state_d = LOAD;
         end
         LOAD: begin
            if (abort_i)             state_d = IDLE;
            else if (xfer) begin
               if (rsvd_err)         state_d = IDLE;
`ifdef CFG_CHECKSUM_EN
               else if (last_cell)   state_d = CHECK;
`else
               else if (last_cell)   state_d = COMMIT;
`endif
            end
         end
         CHECK: begin
`ifdef CFG_CHECKSUM_EN
            if (abort_i)             state_d = IDLE;
            else if (xfer)           state_d = (cfg_data_i == csum_q) ? COMMIT : IDLE;
`else
            state_d = IDLE;
`endif
         end
         COMMIT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs; ready is held low during reset and during the commit cycle
   always_comb begin
      cfg_ready_o  = !rst && (state_q != COMMIT);
      cfg_commit_o = (state_q == COMMIT);
      busy_o       = (state_q != IDLE);
      cfg_loaded_o = loaded_q;
      error_o      = error_q;
   end

   // cell index, checksum, sticky flags, and the shadow and active banks
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q    <= '0;
         error_q  <= 1'b0;
         loaded_q <= 1'b0;
`ifdef CFG_CHECKSUM_EN
         csum_q   <= '0;
`endif
         for (int i = 0; i < NUM_CELLS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (xfer && is_sync) begin
                  idx_q   <= '0;
                  error_q <= 1'b0;
`ifdef CFG_CHECKSUM_EN
                  csum_q  <= '0;
`endif
               end
            end
            LOAD: begin
               if (xfer) begin
                  if (rsvd_err) begin
                     error_q <= 1'b1;
                  end else begin
                     shadow_q[idx_q] <= cfg_data_i[CELL_BITS-1:0];
`ifdef CFG_CHECKSUM_EN
                     csum_q <= csum_q ^ cfg_data_i;
`endif
                     if (!last_cell) idx_q <= idx_q + 1'b1;
                  end
               end
            end
            CHECK: begin
`ifdef CFG_CHECKSUM_EN
               if (xfer && (cfg_data_i != csum_q)) error_q <= 1'b1;
`endif
            end
            COMMIT: begin
               active_q <= shadow_q;
               loaded_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // unpack active cells into the FU and switchbox program structs
   always_comb begin
      for (int i = 0; i < NUM_CELLS; i++) begin
         fu_program_o[i].mode  = active_q[i][2:0];
         sb_program_o[i].a_sel = active_q[i][2+FU_COLS_BITS:3];
         sb_program_o[i].b_sel = active_q[i][CELL_BITS-1:3+FU_COLS_BITS];
      end
   end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader. It covers both the checksum and the
// no-checksum build (CFG_CHECKSUM_EN).

`timescale 1ns/1ps

module tb_fabric_config_loader;
   import fabric_config_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       cfg_data;
   logic             cfg_valid;
   logic             cfg_ready;
   logic             abort;
   fu_program_data_t fu_prog [16];
   sb_program_data_t sb_prog [16];
   logic             cfg_commit;
   logic             cfg_loaded;
   logic             busy;
   logic             error;

   int n_vec    = 0;
   int n_err    = 0;
   int n_commit = 0;

   fabric_config_loader dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_data_i   (cfg_data),
      .cfg_valid_i  (cfg_valid),
      .cfg_ready_o  (cfg_ready),
      .abort_i      (abort),
      .fu_program_o (fu_prog),
      .sb_program_o (sb_prog),
      .cfg_commit_o (cfg_commit),
      .cfg_loaded_o (cfg_loaded),
      .busy_o       (busy),
      .error_o      (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (!rst && cfg_commit) n_commit <= n_commit + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // present one word for one clock; returns at the following negedge
   task automatic send(input logic [7:0] w);
      cfg_data  = w;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_data  = 8'h00;
   endtask

   // pattern A: word i -> mode=i[2:0], a_sel=i[4:3], b_sel=0
   function automatic logic [7:0] word_a(input int i);
      return 8'(i);
   endfunction

   // pattern B: mode=(3i)&7, a_sel=i&3, b_sel=(i>>2)&3
   function automatic logic [7:0] word_b(input int i);
      return 8'(((i * 3) & 7) | ((i & 3) << 3) | (((i >> 2) & 3) << 5));
   endfunction

   logic [7:0] csum;

   initial begin
      rst       = 1'b1;
      cfg_data  = 8'h00;
      cfg_valid = 1'b0;
      abort     = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_ready",  32'(cfg_ready),  32'd0);
      check("rst_busy",   32'(busy),       32'd0);
      check("rst_loaded", 32'(cfg_loaded), 32'd0);
      check("rst_error",  32'(error),      32'd0);
      check("rst_commit", 32'(cfg_commit), 32'd0);
      check("rst_mode5",  32'(fu_prog[5].mode), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", 32'(cfg_ready), 32'd1);

      // frame A
      send(8'hA5);
      check("a_busy_after_sync", 32'(busy), 32'd1);
      for (int i = 0; i < 15; i++) send(word_a(i));
      check("a_busy_cell14", 32'(busy), 32'd1);
      check("a_no_commit_cell14", 32'(n_commit), 32'd0);
      send(word_a(15));
`ifdef CFG_CHECKSUM_EN
      check("a_check_no_commit", 32'(cfg_commit), 32'd0);
      send(8'h00);
`endif
      check("a_commit_pulse", 32'(cfg_commit), 32'd1);
      check("a_commit_ready", 32'(cfg_ready), 32'd0);
      check("a_active_not_yet", 32'(fu_prog[5].mode), 32'd0);
      @(negedge clk);
      check("a_commit_low", 32'(cfg_commit), 32'd0);
      check("a_busy_done", 32'(busy), 32'd0);
      check("a_mode5", 32'(fu_prog[5].mode), 32'd5);
      check("a_asel5", 32'(sb_prog[5].a_sel), 32'd0);
      check("a_mode12", 32'(fu_prog[12].mode), 32'd4);
      check("a_asel12", 32'(sb_prog[12].a_sel), 32'd1);
      check("a_bsel12", 32'(sb_prog[12].b_sel), 32'd0);
      check("a_loaded", 32'(cfg_loaded), 32'd1);
      check("a_error", 32'(error), 32'd0);
      check("a_commit_count", 32'(n_commit), 32'd1);

`ifdef CFG_CHECKSUM_EN
      // bad checksum
      send(8'hA5);
      for (int i = 0; i < 16; i++) send(word_a(i));
      send(8'hFF);
      check("bad_csum_error", 32'(error), 32'd1);
      check("bad_csum_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("bad_csum_no_commit", 32'(n_commit), 32'd1);
      check("bad_csum_mode5", 32'(fu_prog[5].mode), 32'd5);
`endif

      // garbage before sync, then pattern B with valid toggling
      send(8'h12);
      send(8'h34);
      check("garbage_busy", 32'(busy), 32'd0);
      send(8'hA5);
      csum = 8'h00;
      for (int i = 0; i < 16; i++) begin
         send(word_b(i));
         csum ^= word_b(i);
         if (i < 15) begin
            @(negedge clk);
            check("b_stall_busy", 32'(busy), 32'd1);
         end
      end
`ifdef CFG_CHECKSUM_EN
      @(negedge clk);
      send(csum);
`endif
      check("b_commit_pulse", 32'(cfg_commit), 32'd1);
      @(negedge clk);
      check("b_mode6", 32'(fu_prog[6].mode), 32'd2);
      check("b_asel6", 32'(sb_prog[6].a_sel), 32'd2);
      check("b_bsel6", 32'(sb_prog[6].b_sel), 32'd1);
      check("b_mode15", 32'(fu_prog[15].mode), 32'd5);
      check("b_bsel15", 32'(sb_prog[15].b_sel), 32'd3);
      check("b_error", 32'(error), 32'd0);
      check("b_commit_count", 32'(n_commit), 32'd2);

      // abort at cell 7, with a word presented in the same cycle
      send(8'hA5);
      for (int i = 0; i < 7; i++) send(word_a(i));
      abort = 1'b1;
      send(word_a(7));
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_no_commit", 32'(cfg_commit), 32'd0);
      // abort together with a sync word in IDLE drops the word
      abort = 1'b1;
      send(8'hA5);
      abort = 1'b0;
      check("abort_sync_dropped", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      check("abort_commit_count", 32'(n_commit), 32'd2);
      check("abort_active_kept", 32'(fu_prog[6].mode), 32'd2);

      // reserved bit at idx 3
      send(8'hA5);
      for (int i = 0; i < 3; i++) send(word_a(i));
      send(8'h80);
      check("rsvd_error", 32'(error), 32'd1);
      check("rsvd_busy", 32'(busy), 32'd0);
      check("rsvd_active_kept", 32'(sb_prog[6].a_sel), 32'd2);
      send(8'hA5);
      check("resync_error_clear", 32'(error), 32'd0);
      check("resync_busy", 32'(busy), 32'd1);

      // the frame restarts and commits pattern A after the aborted frame
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      send(8'hA5);
      for (int i = 0; i < 16; i++) send(word_a(i));
`ifdef CFG_CHECKSUM_EN
      send(8'h00);
`endif
      @(negedge clk);
      check("a2_mode6", 32'(fu_prog[6].mode), 32'd6);
      check("a2_bsel6", 32'(sb_prog[6].b_sel), 32'd0);
      check("a2_commit_count", 32'(n_commit), 32'd3);

      // reset in the middle of a frame clears the active bank
      send(8'hA5);
      for (int i = 0; i < 4; i++) send(word_b(i));
      rst = 1'b1;
      @(negedge clk);
      check("midrst_mode6", 32'(fu_prog[6].mode), 32'd0);
      check("midrst_loaded", 32'(cfg_loaded), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ready", 32'(cfg_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
